// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - ALU op codes, RV32I opcodes and issue entry type
package alu_defs;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_AND  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0110;
   localparam logic [3:0] ALU_NOR  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_SLL  = 4'b1010;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [3:0]      alu_op;
      logic [4:0]      rd;
      logic            illegal;
   } issue_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - upstream and execute-side handshake bundle
interface alu_issue_stage_if;
   import alu_defs::*;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1_val;
   logic [XLEN-1:0] in_rs2_val;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_a;
   logic [XLEN-1:0] out_b;
   logic [3:0]      out_alu_op;
   logic [4:0]      out_rd;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
      output in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal
   );

endinterface

// File: rtl/alu_issue_stage_decode.sv
// rtl/alu_issue_stage_decode.sv - RV32I opcode/funct decode to ALU operands and op
module alu_op_decode
   import alu_defs::*;
(
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic [XLEN-1:0] o_a,
   output logic [XLEN-1:0] o_b,
   output logic [3:0]      o_alu_op,
   output logic            o_illegal
);

   logic [6:0]      w_opcode;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_shamt;
   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_b;
   logic [3:0]      w_op;
   logic            w_legal;

   assign w_opcode = i_instr[6:0];
   assign w_f3     = i_instr[14:12];
   assign w_f7     = i_instr[31:25];
   assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign w_imm_u  = {i_instr[31:12], 12'b0};
   assign w_shamt  = {27'b0, i_instr[24:20]};

   always_comb begin
      w_a     = '0;
      w_b     = '0;
      w_op    = ALU_ADD;
      w_legal = 1'b1;
      case (w_opcode)
         OPC_OP: begin
            w_a = i_rs1;
            w_b = i_rs2;
            case (w_f3)
               3'b000:  w_op = (w_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
               3'b001:  w_op = ALU_SLL;
               3'b010:  w_op = ALU_SLT;
               3'b011:  w_op = ALU_SLTU;
               3'b100:  w_op = ALU_XOR;
               3'b101:  w_op = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
               3'b110:  w_op = ALU_OR;
               default: w_op = ALU_AND;
            endcase
            // F7_ALT only selects sub and sra; every other encoding is reserved
            if (w_f7 != F7_BASE && !(w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)))
               w_legal = 1'b0;
         end
         OPC_OP_IMM: begin
            w_a = i_rs1;
            w_b = w_imm_i;
            case (w_f3)
               3'b000: w_op = ALU_ADD;
               3'b001: begin
                  w_op    = ALU_SLL;
                  w_b     = w_shamt;
                  w_legal = (w_f7 == F7_BASE);
               end
               3'b010: w_op = ALU_SLT;
               3'b011: w_op = ALU_SLTU;
               3'b100: w_op = ALU_XOR;
               3'b101: begin
                  w_op    = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  w_b     = w_shamt;
                  w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
               end
               3'b110:  w_op = ALU_OR;
               default: w_op = ALU_AND;
            endcase
         end
         OPC_LOAD: begin
            w_a = i_rs1;
            w_b = w_imm_i;
         end
         OPC_STORE: begin
            w_a = i_rs1;
            w_b = w_imm_s;
         end
         OPC_LUI:   w_b = w_imm_u;
         OPC_AUIPC: begin
            w_a = i_pc;
            w_b = w_imm_u;
         end
         OPC_BRANCH: begin
            w_a = i_rs1;
            w_b = i_rs2;
            case (w_f3)
               3'b000, 3'b001: w_op = ALU_SUB;
               3'b100, 3'b101: w_op = ALU_SLT;
               3'b110, 3'b111: w_op = ALU_SLTU;
               default:        w_legal = 1'b0;
            endcase
         end
         OPC_JAL, OPC_JALR: begin
            w_a     = i_pc;
            w_b     = 32'd4;
            w_legal = (w_opcode == OPC_JAL) || (w_f3 == 3'b000);
         end
         default: w_legal = 1'b0;
      endcase
   end

   assign o_a       = w_legal ? w_a : '0;
   assign o_b       = w_legal ? w_b : '0;
   assign o_alu_op  = w_legal ? w_op : ALU_ADD;
   assign o_illegal = ~w_legal;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered issue stage with 2-entry skid buffer
module alu_issue_stage
   import alu_defs::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   alu_issue_stage_if.slave   bus
);

   issue_t r_out;
   issue_t r_skid;
   logic   r_out_valid;
   logic   r_skid_valid;
   issue_t w_dec;
   logic   w_accept;
   logic   w_out_free;

   alu_op_decode u_decode (
      .i_instr   (bus.in_instr),
      .i_pc      (bus.in_pc),
      .i_rs1     (bus.in_rs1_val),
      .i_rs2     (bus.in_rs2_val),
      .o_a       (w_dec.a),
      .o_b       (w_dec.b),
      .o_alu_op  (w_dec.alu_op),
      .o_illegal (w_dec.illegal)
   );
   assign w_dec.rd = bus.in_instr[11:7];

   assign w_accept   = bus.in_valid & ~r_skid_valid;
   assign w_out_free = ~r_out_valid | bus.out_ready;

   // in_ready depends only on the skid register, so no comb path from out_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out        <= '0;
         r_skid       <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else begin
            if (w_accept)
               r_out <= w_dec;
            r_out_valid <= w_accept;
         end
      end else if (w_accept) begin
         r_skid       <= w_dec;
         r_skid_valid <= 1'b1;
      end
   end

   assign bus.in_ready    = ~r_skid_valid;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_a       = r_out.a;
   assign bus.out_b       = r_out.b;
   assign bus.out_alu_op  = r_out.alu_op;
   assign bus.out_rd      = r_out.rd;
   assign bus.out_illegal = r_out.illegal;

endmodule
